// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-at-a-time requests to
// instruction memory, presents returned words to IF/ID and reports if_wait
// to the hazard unit. A one-entry hold buffer catches a word that returns
// while IF/ID is paused. A fetch squashed by a redirect is tracked so that
// its late response is dropped.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_pause,
    input  logic        ex_jump,
    input  logic [31:0] ex_jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_wait
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_hold_valid;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc;

    logic        w_req;
    logic        w_accept;
    logic        w_rsp_live;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic        w_wait;
    logic [31:0] w_jump_pc;
    logic        w_unused;

    // The low target bits are dropped: instructions are word aligned.
    assign w_jump_pc  = {ex_jump_target[31:2], 2'b00};
    assign w_unused   = ^ex_jump_target[1:0];

    // A request is accepted only when we are actually asking for one.
    assign w_accept   = w_req & imem_gnt;

    // A response belongs to us only while a live fetch is outstanding;
    // anything seen in FETCH is stale (e.g. from before a reset).
    assign w_rsp_live = (r_state == S_WAIT) & imem_rvalid;

    assign imem_req   = w_req;
    assign imem_addr  = r_pc;
    assign if_inst    = w_inst;
    assign if_pc      = w_pc;
    assign if_wait    = w_wait;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a redirect overrides normal sequencing and decides
    // whether one response is still owed by memory.
    always_comb begin
        w_state_next = r_state;
        if (ex_jump) begin
            if ((r_state == S_WAIT && !imem_rvalid) ||
                (r_state == S_FETCH && w_accept) ||
                (r_state == S_DROP && !imem_rvalid)) begin
                w_state_next = S_DROP;
            end else begin
                w_state_next = S_FETCH;
            end
        end else begin
            case (r_state)
                S_FETCH: if (w_accept)    w_state_next = S_WAIT;
                S_WAIT:  if (imem_rvalid) w_state_next = S_FETCH;
                S_DROP:  if (imem_rvalid) w_state_next = S_FETCH;
                default:                  w_state_next = S_FETCH;
            endcase
        end
    end

    // Outputs: hold buffer first, then a live memory response; a redirect
    // cycle always reports "not waiting" so the hazard unit takes the jump.
    always_comb begin
        w_req  = 1'b0;
        w_wait = 1'b1;
        w_inst = 32'h0;
        w_pc   = 32'h0;
        if (!rst) begin
            w_req = (r_state == S_FETCH) && !r_hold_valid;
            if (r_hold_valid) begin
                w_inst = r_hold_inst;
                w_pc   = r_hold_pc;
                w_wait = 1'b0;
            end else if (w_rsp_live) begin
                w_inst = imem_rdata;
                w_pc   = r_req_pc;
                w_wait = 1'b0;
            end
            if (ex_jump) begin
                w_wait = 1'b0;
            end
        end
    end

    // PC, outstanding-fetch address and hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_req_pc     <= 32'h0;
            r_hold_valid <= 1'b0;
            r_hold_inst  <= 32'h0;
            r_hold_pc    <= 32'h0;
        end else begin
            if (w_accept) begin
                r_req_pc <= r_pc;
            end
            if (ex_jump) begin
                r_pc         <= w_jump_pc;
                r_hold_valid <= 1'b0;
            end else begin
                if (r_hold_valid && !pc_pause) begin
                    r_hold_valid <= 1'b0;
                end
                if (w_rsp_live) begin
                    r_pc <= r_req_pc + 32'd4;
                    if (pc_pause) begin
                        r_hold_valid <= 1'b1;
                        r_hold_inst  <= imem_rdata;
                        r_hold_pc    <= r_req_pc;
                    end
                end
            end
        end
    end

endmodule
